// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone single-transfer master: state encoding
// and default bus widths.
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUS  = 2'd1,
    WB_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_master_ctrl_if.sv
// Request/response channels and Wishbone B4 classic signals of wb_master_ctrl,
// with the controller (master) and environment (slave) views.
interface wb_master_ctrl_if import wb_pkg::*; #(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) ();

  localparam int SEL_W = DATA_W / 8;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [SEL_W-1:0]  req_sel_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              we_o;
  logic [SEL_W-1:0]  sel_o;
  logic              cyc_o;
  logic              stb_o;
  logic              ack_i;
  logic              err_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    input  rsp_ready_i, dat_i, ack_i, err_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    output rsp_ready_i, dat_i, ack_i, err_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts BUS cycles without ack/err and flags the edge on
// which TIMEOUT_CYCLES is reached.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic done_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count idle bus cycles; anything other than a waiting BUS cycle restarts at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (busy_i && !done_i) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // The count reaches the limit on the edge that ends the last waiting cycle
  always_comb begin
    expired_o = busy_i && !done_i && (cnt_r == LAST_CNT);
  end

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone B4 classic single-transfer master with valid/ready request and
// response channels. Optional bus watchdog enabled by WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl import wb_pkg::*; #(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_master_ctrl_if.master  bus
);

  localparam int SEL_W = DATA_W / 8;

  wb_state_e         state_r;
  logic              ready_r;
  logic [ADDR_W-1:0] adr_r;
  logic [DATA_W-1:0] dat_r;
  logic [SEL_W-1:0]  sel_r;
  logic              we_r;
  logic              cyc_r;
  logic              stb_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              done_s;
  logic              timeout_s;

  assign done_s = bus.ack_i | bus.err_i;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .busy_i    (state_r == WB_BUS),
    .done_i    (done_s),
    .expired_o (timeout_s)
  );
`else
  logic timeout_unused_s;
  assign timeout_unused_s = ^32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  // Transfer FSM with registered bus and response outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= WB_IDLE;
      ready_r     <= 1'b1;
      adr_r       <= '0;
      dat_r       <= '0;
      sel_r       <= '0;
      we_r        <= 1'b0;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        WB_IDLE: begin
          if (bus.req_valid_i) begin
            adr_r   <= bus.req_addr_i;
            dat_r   <= bus.req_wdata_i;
            sel_r   <= bus.req_sel_i;
            we_r    <= bus.req_we_i;
            cyc_r   <= 1'b1;
            stb_r   <= 1'b1;
            ready_r <= 1'b0;
            state_r <= WB_BUS;
          end
        end
        WB_BUS: begin
          // A slave reply on the expiry edge beats the watchdog
          if (done_s) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= bus.err_i;
            rsp_rdata_r <= (!we_r && !bus.err_i) ? bus.dat_i : '0;
            state_r     <= WB_RESP;
          end else if (timeout_s) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= '0;
            state_r     <= WB_RESP;
          end
        end
        WB_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            ready_r     <= 1'b1;
            state_r     <= WB_IDLE;
          end
        end
        default: begin
          cyc_r       <= 1'b0;
          stb_r       <= 1'b0;
          we_r        <= 1'b0;
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          state_r     <= WB_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = ready_r;
  assign bus.adr_o       = adr_r;
  assign bus.dat_o       = dat_r;
  assign bus.sel_o       = sel_r;
  assign bus.we_o        = we_r;
  assign bus.cyc_o       = cyc_r;
  assign bus.stb_o       = stb_r;
  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_rdata_o = rsp_rdata_r;
  assign bus.rsp_err_o   = rsp_err_r;

endmodule
